mlp_result_collector: RTL and testbench
=======================================

# mlp_result_collector

Store-and-forward result collector that sits directly downstream of the MVM crossbar's output passthrough. It consumes result packets addressed to the output port, buffers each packet until it is complete, and forwards whole packets to the host-side AXI-Stream with TDEST rewritten to the host destination. It enforces a fixed result packet length and reports length violations, so that a partially produced packet never reaches the host.

## Interface
Parameters:
- DATAW, 32, data beat width
- IDW, 32, TID width
- USERW, 32, TUSER width
- DESTW, 6, TDEST width
- DEPTH, 64, buffer depth in beats; must be a power of 2 and ≥ 2*PKT_BEATS
- ADDRW, 6, log2(DEPTH), hardcoded
- PKT_BEATS, 4, expected beats per result packet (≥ 1)
- HOST_DEST, 0, TDEST value driven on every output beat
- CNTW, 16, width of the packet counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- AXIS_S_TVALID  in  1  input beat valid
- AXIS_S_TREADY  out  1  input ready
- AXIS_S_TDATA  in  DATAW  input data
- AXIS_S_TLAST  in  1  input end of packet
- AXIS_S_TID  in  IDW  input ID
- AXIS_S_TUSER  in  USERW  input user
- AXIS_S_TDEST  in  DESTW  input dest (ignored)
- AXIS_M_TVALID  out  1  output valid
- AXIS_M_TREADY  in  1  output ready
- AXIS_M_TDATA  out  DATAW  output data
- AXIS_M_TLAST  out  1  output end of packet
- AXIS_M_TID  out  IDW  output ID
- AXIS_M_TUSER  out  USERW  output user
- AXIS_M_TDEST  out  DESTW  always HOST_DEST
- LEN_ERR_CLR  in  1  single-cycle clear of LEN_ERR
- LEN_ERR  out  1  sticky packet length violation flag
- PKT_COUNT  out  CNTW  packets delivered on the output

## Operation
- Buffer: DEPTH-entry RAM of {TDATA, TLAST, TID, TUSER}. Pointers wr_ptr, cmt_ptr and rd_ptr are each ADDRW+1 bits. Occupancy is wr_ptr − rd_ptr. The buffer is full at DEPTH and empty when rd_ptr == cmt_ptr.
- AXIS_S_TREADY = !rst && occupancy < DEPTH. It is a registered-state function, with no combinational path from AXIS_M_TREADY.
- Input beat counter in_beats, range 0..PKT_BEATS−1. On each input handshake:
  - The beat is written at wr_ptr, wr_ptr increments, and in_beats increments.
  - End of packet occurs when TLAST=1 or in_beats == PKT_BEATS−1. At end of packet the stored TLAST is 1, in_beats resets to 0, and cmt_ptr is set to the new wr_ptr on the next clock.
  - Short packet (TLAST=1 with in_beats < PKT_BEATS−1): LEN_ERR is set and the packet is still committed as received.
  - Long packet (in_beats == PKT_BEATS−1 with TLAST=0): LEN_ERR is set, the packet is truncated (stored TLAST forced to 1), and the following beats start a new packet.
- Output stage: a single output register. When the register is empty, or holds a beat being accepted this cycle, and the buffer is non-empty, the register loads the entry at rd_ptr and rd_ptr increments. This sustains 1 beat/cycle.
- AXIS_M_TDEST = HOST_DEST. TID and TUSER pass through per beat.
- PKT_COUNT increments on every output handshake with TLAST=1 and wraps modulo 2^CNTW.
- LEN_ERR: if set and LEN_ERR_CLR occur in the same cycle, set wins.

## Timing
- Reset values: AXIS_S_TREADY=0 while rst is high, then 1 in the first cycle after rst deasserts. AXIS_M_TVALID=0, and AXIS_M_TDATA/TLAST/TID/TUSER=0. LEN_ERR=0, PKT_COUNT=0. All pointers and in_beats are 0.
- Latency: if the last beat of a packet handshakes in cycle T, cmt_ptr is updated at T+1. The first beat of that packet appears on AXIS_M_TVALID at T+2 at the earliest.
- No beat of a packet is presented until the whole packet is committed. Beats of a committed packet stream back-to-back while AXIS_M_TREADY=1.
- AXIS_M_* stays stable while AXIS_M_TVALID=1 and AXIS_M_TREADY=0.
- Simultaneous write and read in one cycle are both performed; occupancy is unchanged.
- At full, TREADY drops in the cycle after the DEPTH-th unread beat is written. Because DEPTH ≥ 2*PKT_BEATS, a full buffer always holds at least one committed packet, so no deadlock occurs.
- Pointer wrap at DEPTH is transparent.
- Reset mid-packet discards all buffered and uncommitted beats; the partial packet is never emitted.

## Test plan
- Single packet: 4 beats with data 0x11..0x44, TLAST on beat 4, M_TREADY=1 → output beats 0x11..0x44 start at T+2, TDEST=0, TLAST on the 4th, PKT_COUNT=1, LEN_ERR=0.
- Short packet: 2 beats with TLAST on beat 2 → 2-beat packet emitted, LEN_ERR=1. LEN_ERR_CLR pulse → LEN_ERR=0. Set and clear in the same cycle → LEN_ERR stays 1.
- Long packet: 6 beats with TLAST only on beat 6 → packet of beats 1–4 with TLAST on beat 4, LEN_ERR=1. Beats 5–6 form a 2-beat packet, PKT_COUNT=2.
- Backpressure/full: M_TREADY=0 while 20 packets are offered → S_TREADY=0 once occupancy reaches 64. M_TREADY=1 → all 80 beats delivered in order, PKT_COUNT=20, no loss or duplication.
- Reset mid-packet: assert rst after 2 of 4 beats → no output. A following clean 4-beat packet is emitted alone, PKT_COUNT=1.
- Random valid/ready over 1000 packets, checked against a scoreboard; also force PKT_COUNT wrap with CNTW=4 → PKT_COUNT returns to 0 after 16 packets.

Source files
------------

// File: rtl/mlp_result_collector_if.sv
// AXI-Stream style beat bundle shared by the collector's input and output ports.
interface mlp_result_collector_if #(
    parameter int DATAW = 32,
    parameter int IDW   = 32,
    parameter int USERW = 32,
    parameter int DESTW = 6
);
    logic             tvalid;
    logic             tready;
    logic [DATAW-1:0] tdata;
    logic             tlast;
    logic [IDW-1:0]   tid;
    logic [USERW-1:0] tuser;
    logic [DESTW-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tuser, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tuser, tdest, output tready);
endinterface

// File: rtl/mlp_result_collector.sv
// Store-and-forward result collector: buffers each result packet until it is
// complete, enforces a fixed packet length, and forwards whole packets to the
// host stream with the destination rewritten to HOST_DEST.
module mlp_result_collector #(
    parameter int DATAW     = 32,
    parameter int IDW       = 32,
    parameter int USERW     = 32,
    parameter int DESTW     = 6,
    parameter int DEPTH     = 64,
    parameter int ADDRW     = 6,
    parameter int PKT_BEATS = 4,
    parameter int HOST_DEST = 0,
    parameter int CNTW      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mlp_result_collector_if.slave  axis_s,
    mlp_result_collector_if.master axis_m,
    input  logic                  len_err_clr,
    output logic                  len_err,
    output logic [CNTW-1:0]       pkt_count
);
    localparam int BEATW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(PKT_BEATS - 1);
    localparam int ENTW = DATAW + 1 + IDW + USERW;

    // Buffer entry layout: {tdata, tlast, tid, tuser}
    logic [ENTW-1:0]  mem [DEPTH];

    logic [ADDRW:0]   wr_ptr_reg;
    logic [ADDRW:0]   cmt_ptr_reg;
    logic [ADDRW:0]   rd_ptr_reg;
    logic [BEATW-1:0] in_beats_reg;
    logic             m_valid_reg;
    logic [ENTW-1:0]  m_entry_reg;
    logic             len_err_reg;
    logic [CNTW-1:0]  pkt_count_reg;

    logic [ADDRW:0]   occupancy;
    logic             full;
    logic             empty;
    logic             in_hs;
    logic             at_last;
    logic             eop;
    logic             short_pkt;
    logic             long_pkt;
    logic             out_hs;
    logic             load;
    logic             unused_dest;

    // The incoming destination is always the output port, so it carries no information here.
    assign unused_dest = ^axis_s.tdest;

    // Occupancy counts everything written but not yet moved into the output
    // register; only committed beats (up to cmt_ptr) are readable.
    assign occupancy = wr_ptr_reg - rd_ptr_reg;
    assign full      = occupancy[ADDRW];
    assign empty     = (rd_ptr_reg == cmt_ptr_reg);

    assign axis_s.tready = !rst && !full;
    assign in_hs     = axis_s.tvalid && axis_s.tready;
    assign at_last   = (in_beats_reg == LAST_BEAT);
    assign eop       = axis_s.tlast || at_last;
    assign short_pkt = in_hs && axis_s.tlast && !at_last;
    assign long_pkt  = in_hs && !axis_s.tlast && at_last;

    assign out_hs = m_valid_reg && axis_m.tready;
    assign load   = (!m_valid_reg || axis_m.tready) && !empty;

    // Buffer write port; stored tlast marks the committed packet boundary.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem[wr_ptr_reg[ADDRW-1:0]] <= {axis_s.tdata, eop, axis_s.tid, axis_s.tuser};
        end
    end

    // Input side: write pointer, beat-in-packet counter and commit pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            cmt_ptr_reg  <= '0;
            in_beats_reg <= '0;
        end else if (in_hs) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (eop) begin
                in_beats_reg <= '0;
                cmt_ptr_reg  <= wr_ptr_reg + 1'b1;
            end else begin
                in_beats_reg <= in_beats_reg + 1'b1;
            end
        end
    end

    // Output register doubles as the registered RAM read; it refills in the
    // same cycle its beat is taken so committed packets stream at full rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg  <= '0;
            m_valid_reg <= 1'b0;
            m_entry_reg <= '0;
        end else if (load) begin
            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            m_valid_reg <= 1'b1;
            m_entry_reg <= mem[rd_ptr_reg[ADDRW-1:0]];
        end else if (out_hs) begin
            m_valid_reg <= 1'b0;
        end
    end

    // Sticky length-violation flag; a new violation outranks a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_err_reg <= 1'b0;
        end else if (short_pkt || long_pkt) begin
            len_err_reg <= 1'b1;
        end else if (len_err_clr) begin
            len_err_reg <= 1'b0;
        end
    end

    // Count packets delivered to the host; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_reg <= '0;
        end else if (out_hs && axis_m.tlast) begin
            pkt_count_reg <= pkt_count_reg + 1'b1;
        end
    end

    assign axis_m.tvalid = m_valid_reg;
    assign axis_m.tdata  = m_entry_reg[ENTW-1 -: DATAW];
    assign axis_m.tlast  = m_entry_reg[IDW+USERW];
    assign axis_m.tid    = m_entry_reg[USERW +: IDW];
    assign axis_m.tuser  = m_entry_reg[USERW-1:0];
    assign axis_m.tdest  = DESTW'(HOST_DEST);

    assign len_err   = len_err_reg;
    assign pkt_count = pkt_count_reg;
endmodule

// File: tb/tb_mlp_result_collector.sv
// Directed and table-driven bench for mlp_result_collector with a beat scoreboard.
module tb_mlp_result_collector;
    localparam int DATAW = 32;
    localparam int IDW   = 32;
    localparam int USERW = 32;
    localparam int DESTW = 6;

    logic clk = 1'b0;
    logic rst;
    logic len_err_clr;
    logic len_err;
    logic len_err4;
    logic [15:0] pkt_count;
    logic [3:0]  pkt_count4;

    always #5 clk = ~clk;

    mlp_result_collector_if #(.DATAW(DATAW), .IDW(IDW), .USERW(USERW), .DESTW(DESTW)) s_if ();
    mlp_result_collector_if #(.DATAW(DATAW), .IDW(IDW), .USERW(USERW), .DESTW(DESTW)) m_if ();
    mlp_result_collector_if #(.DATAW(DATAW), .IDW(IDW), .USERW(USERW), .DESTW(DESTW)) s4_if ();
    mlp_result_collector_if #(.DATAW(DATAW), .IDW(IDW), .USERW(USERW), .DESTW(DESTW)) m4_if ();

    mlp_result_collector dut (
        .clk(clk), .rst(rst), .axis_s(s_if.slave), .axis_m(m_if.master),
        .len_err_clr(len_err_clr), .len_err(len_err), .pkt_count(pkt_count)
    );

    // Second instance with a 4-bit packet counter, fed the same traffic.
    mlp_result_collector #(.CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .axis_s(s4_if.slave), .axis_m(m4_if.master),
        .len_err_clr(len_err_clr), .len_err(len_err4), .pkt_count(pkt_count4)
    );

    assign s4_if.tvalid = s_if.tvalid;
    assign s4_if.tdata  = s_if.tdata;
    assign s4_if.tlast  = s_if.tlast;
    assign s4_if.tid    = s_if.tid;
    assign s4_if.tuser  = s_if.tuser;
    assign s4_if.tdest  = s_if.tdest;
    assign m4_if.tready = m_if.tready;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] id;
        logic [31:0] user;
    } beat_t;

    typedef struct {
        int          nbeats;
        logic [7:0]  last_mask;
        logic        exp_err;
        int          exp_delta;
    } vec_t;

    beat_t exp_q[$];
    vec_t  tbl[6];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    in_cnt = 0;
    logic  exp_err = 1'b0;
    int    out_pkts = 0;
    int    exp_total = 0;
    int    accepted = 0;
    int    last_hs_cyc = 0;
    int    first_valid_cyc = 0;
    int    last_out_cyc = 0;
    logic  prev_valid = 1'b0;
    logic  hold_pend = 1'b0;
    logic [31:0] hold_data = '0;
    logic  done;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_valid = 1'b0;
            hold_pend  = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(m_if.tvalid), 64'd1);
                check("hold_data", 64'(m_if.tdata), 64'(hold_data));
            end
            if (m_if.tvalid && !prev_valid) first_valid_cyc = cyc;
            prev_valid = m_if.tvalid;
            hold_pend  = m_if.tvalid && !m_if.tready;
            hold_data  = m_if.tdata;
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(m_if.tdata), 64'hDEAD_0000_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(m_if.tdata), 64'(e.data));
                    check("out_last", 64'(m_if.tlast), 64'(e.last));
                    check("out_id", 64'(m_if.tid), 64'(e.id));
                    check("out_user", 64'(m_if.tuser), 64'(e.user));
                    check("out_dest", 64'(m_if.tdest), 64'd0);
                    if (e.last) begin
                        out_pkts++;
                        last_out_cyc = cyc;
                        $display("[TB] packet %0d delivered, last data 0x%08h, cycle %0d", out_pkts, m_if.tdata, cyc);
                    end
                end
            end
        end
    end

    // Offer one beat and wait (bounded) for its handshake; updates the model.
    task automatic send_beat(input logic [31:0] d, input logic l, input logic clr);
        int   waited;
        logic rdy;
        logic eop;
        waited = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tid    = d ^ 32'hA5A5_0000;
        s_if.tuser  = ~d;
        s_if.tdest  = d[5:0];
        len_err_clr = clr;
        do begin
            rdy = s_if.tready;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 2000);
        if (!rdy) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            eop = l || (in_cnt == 3);
            if ((l && in_cnt < 3) || (!l && in_cnt == 3)) exp_err = 1'b1;
            exp_q.push_back('{data: d, last: eop, id: d ^ 32'hA5A5_0000, user: ~d});
            in_cnt = eop ? 0 : in_cnt + 1;
            accepted++;
            last_hs_cyc = cyc;
        end
        s_if.tvalid = 1'b0;
        len_err_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        len_err_clr = 1'b1;
        @(posedge clk);
        #1;
        len_err_clr = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        len_err_clr = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        s_if.tid = '0;
        s_if.tuser = '0;
        s_if.tdest = '0;
        m_if.tready = 1'b1;

        // {beats, tlast mask (bit b = beat b), expected LEN_ERR, expected packets out}
        tbl[0] = '{4, 8'b0000_1000, 1'b0, 1};
        tbl[1] = '{2, 8'b0000_0010, 1'b1, 1};
        tbl[2] = '{6, 8'b0010_0000, 1'b1, 2};
        tbl[3] = '{1, 8'b0000_0001, 1'b1, 1};
        tbl[4] = '{8, 8'b1000_1000, 1'b0, 2};
        tbl[5] = '{4, 8'b0000_0000, 1'b1, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_if.tdata), 64'd0);
        check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_m_tid", 64'(m_if.tid), 64'd0);
        check("rst_m_tuser", 64'(m_if.tuser), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_s_tready", 64'(s_if.tready), 64'd1);

        // Single packet: first output beat at T+2, burst back-to-back
        send_beat(32'h11, 1'b0, 1'b0);
        send_beat(32'h22, 1'b0, 1'b0);
        send_beat(32'h33, 1'b0, 1'b0);
        send_beat(32'h44, 1'b1, 1'b0);
        begin
            int t_last;
            t_last = last_hs_cyc;
            drain();
            check("lat_first_valid", 64'(first_valid_cyc), 64'(t_last + 1));
        end
        check("lat_burst_len", 64'(last_out_cyc - first_valid_cyc), 64'd3);
        exp_total = 1;
        check("single_pkt_count", 64'(pkt_count), 64'(exp_total));
        check("single_len_err", 64'(len_err), 64'd0);

        // Table-driven packet shapes
        for (int v = 0; v < 6; v++) begin
            pulse_clr();
            for (int b = 0; b < tbl[v].nbeats; b++) begin
                send_beat({8'(v), 8'(b), 16'hBEEF}, tbl[v].last_mask[b], 1'b0);
            end
            drain();
            exp_total += tbl[v].exp_delta;
            check("tbl_len_err", 64'(len_err), 64'(tbl[v].exp_err));
            check("tbl_pkt_count", 64'(pkt_count), 64'(exp_total));
            check("tbl_pkt_count4", 64'(pkt_count4), 64'(exp_total % 16));
        end

        // LEN_ERR clear, then set and clear in the same cycle
        pulse_clr();
        check("clr_len_err", 64'(len_err), 64'd0);
        send_beat(32'hC0, 1'b0, 1'b0);
        send_beat(32'hC1, 1'b1, 1'b1);
        drain();
        exp_total += 1;
        check("set_wins_len_err", 64'(len_err), 64'd1);
        pulse_clr();
        check("clr2_len_err", 64'(len_err), 64'd0);

        // Backpressure until full, then release
        m_if.tready = 1'b0;
        accepted = 0;
        fork
            begin
                for (int p = 0; p < 20; p++) begin
                    for (int b = 0; b < 4; b++) begin
                        send_beat(32'h5000_0000 | (p << 8) | b, b == 3, 1'b0);
                    end
                end
            end
            begin
                repeat (150) @(posedge clk);
                #1;
                check("full_s_tready", 64'(s_if.tready), 64'd0);
                check("full_accepted", 64'(accepted), 64'd65);
                m_if.tready = 1'b1;
            end
        join
        drain();
        exp_total += 20;
        check("bp_pkt_count", 64'(pkt_count), 64'(exp_total));
        check("bp_pkt_count4", 64'(pkt_count4), 64'(exp_total % 16));

        // Reset in the middle of a packet
        send_beat(32'hE0, 1'b0, 1'b0);
        send_beat(32'hE1, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        in_cnt = 0;
        exp_err = 1'b0;
        exp_total = 0;
        out_pkts = 0;
        @(posedge clk);
        #1;
        check("midrst_s_tready", 64'(s_if.tready), 64'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_output", 64'(m_if.tvalid), 64'd0);
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        for (int b = 0; b < 4; b++) send_beat(32'hF0 + b, b == 3, 1'b0);
        drain();
        check("midrst_clean_pkt", 64'(pkt_count), 64'd1);
        check("midrst_clean_pkt4", 64'(pkt_count4), 64'd1);

        // Random valid/ready traffic against the scoreboard
        pulse_clr();
        done = 1'b0;
        fork
            begin
                int n;
                for (int p = 0; p < 1000; p++) begin
                    n = $urandom_range(1, 6);
                    for (int b = 0; b < n; b++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        send_beat($urandom, b == n - 1, 1'b0);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_if.tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_if.tready = 1'b1;
        drain();
        check("rnd_len_err", 64'(len_err), 64'(exp_err));
        check("rnd_pkt_count", 64'(pkt_count), 64'(16'(out_pkts)));
        check("rnd_pkt_count4", 64'(pkt_count4), 64'(4'(out_pkts)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
